id_stage_pipe: RTL and testbench

//  Parametrised MIPS decode stage with a built-in ID/EX pipeline register.
//  - Decodes the logic/shift/imm subset, forwards from NUM_FWD later stages, detects load-use hazards.
//  - Registers decoded fields under a valid/ready handshake; inserts a bubble while stalled.
//  - Sits between the IF/ID register and the EX stage; drives regfile read ports.

---
 rtl/id_stage_pipe_pkg.sv | 160 ++++++++++++++++
 rtl/id_stage_pipe_fwd_mux.sv | 26 ++
 rtl/id_stage_pipe.sv | 136 +++++++++++++
 tb/tb_id_stage_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared decode definitions for id_stage_pipe: opcode/func codes, aluop/alusel codes,
// immediate-extension ops, the decoded-field struct and the decode/extend helpers.
package id_stage_pipe_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_PREF    = 6'h33;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_SYNC = 6'h0F;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;

  localparam logic [7:0] ALUOP_NOP  = 8'h00;
  localparam logic [7:0] ALUOP_AND  = 8'h24;
  localparam logic [7:0] ALUOP_OR   = 8'h25;
  localparam logic [7:0] ALUOP_XOR  = 8'h26;
  localparam logic [7:0] ALUOP_NOR  = 8'h27;
  localparam logic [7:0] ALUOP_SLL  = 8'h7C;
  localparam logic [7:0] ALUOP_SRL  = 8'h02;
  localparam logic [7:0] ALUOP_SRA  = 8'h03;
  localparam logic [7:0] ALUOP_SLLV = 8'h04;
  localparam logic [7:0] ALUOP_SRLV = 8'h06;
  localparam logic [7:0] ALUOP_SRAV = 8'h07;

  localparam logic [2:0] ALUSEL_NOP   = 3'b000;
  localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
  localparam logic [2:0] ALUSEL_SHIFT = 3'b010;

`ifdef ID_ARITH_EN
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;
  localparam logic [7:0] ALUOP_ADD   = 8'h20;
  localparam logic [7:0] ALUOP_ADDU  = 8'h21;
  localparam logic [7:0] ALUOP_SUB   = 8'h22;
  localparam logic [7:0] ALUOP_SUBU  = 8'h23;
  localparam logic [7:0] ALUOP_SLT   = 8'h2A;
  localparam logic [7:0] ALUOP_SLTU  = 8'h2B;
  localparam logic [7:0] ALUOP_ADDI  = 8'h55;
  localparam logic [7:0] ALUOP_ADDIU = 8'h56;
  localparam logic [2:0] ALUSEL_ARITH = 3'b100;
`endif

  typedef enum logic [1:0] {EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_SA} ext_op_e;

  typedef struct packed {
    logic [7:0] aluop;
    logic [2:0] alusel;
    logic       reg1_read;
    logic       reg2_read;
    logic       wreg;
    logic [4:0] wd;
    ext_op_e    ext;
    logic       invalid;
  } dec_t;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input logic [4:0] sa,
                                             input ext_op_e op);
    logic [31:0] v;
    case (op)
      EXT_SIGN: v = {{16{imm[15]}}, imm};
      EXT_LUI:  v = {imm, 16'h0000};
      EXT_SA:   v = {27'd0, sa};
      default:  v = {16'h0000, imm};
    endcase
    return v;
  endfunction

  function automatic dec_t decode(input logic [31:0] inst);
    dec_t d;
    d = '0;
    unique case (inst[31:26])
      OP_SPECIAL: begin
        d.reg1_read = 1'b1;
        d.reg2_read = 1'b1;
        d.wreg      = 1'b1;
        d.wd        = inst[15:11];
        unique case (inst[5:0])
          FN_AND:  {d.aluop, d.alusel} = {ALUOP_AND,  ALUSEL_LOGIC};
          FN_OR:   {d.aluop, d.alusel} = {ALUOP_OR,   ALUSEL_LOGIC};
          FN_XOR:  {d.aluop, d.alusel} = {ALUOP_XOR,  ALUSEL_LOGIC};
          FN_NOR:  {d.aluop, d.alusel} = {ALUOP_NOR,  ALUSEL_LOGIC};
          FN_SLLV: {d.aluop, d.alusel} = {ALUOP_SLLV, ALUSEL_SHIFT};
          FN_SRLV: {d.aluop, d.alusel} = {ALUOP_SRLV, ALUSEL_SHIFT};
          FN_SRAV: {d.aluop, d.alusel} = {ALUOP_SRAV, ALUSEL_SHIFT};
          FN_SLL, FN_SRL, FN_SRA: begin
            // Constant shifts carry sa as operand 1 through the immediate path.
            d.reg1_read = 1'b0;
            d.ext       = EXT_SA;
            d.alusel    = ALUSEL_SHIFT;
            d.aluop     = (inst[5:0] == FN_SLL) ? ALUOP_SLL :
                          (inst[5:0] == FN_SRL) ? ALUOP_SRL : ALUOP_SRA;
          end
          FN_SYNC: begin
            d.reg1_read = 1'b0;
            d.reg2_read = 1'b0;
            d.wreg      = 1'b0;
          end
`ifdef ID_ARITH_EN
          FN_ADD:  {d.aluop, d.alusel} = {ALUOP_ADD,  ALUSEL_ARITH};
          FN_ADDU: {d.aluop, d.alusel} = {ALUOP_ADDU, ALUSEL_ARITH};
          FN_SUB:  {d.aluop, d.alusel} = {ALUOP_SUB,  ALUSEL_ARITH};
          FN_SUBU: {d.aluop, d.alusel} = {ALUOP_SUBU, ALUSEL_ARITH};
          FN_SLT:  {d.aluop, d.alusel} = {ALUOP_SLT,  ALUSEL_ARITH};
          FN_SLTU: {d.aluop, d.alusel} = {ALUOP_SLTU, ALUSEL_ARITH};
`endif
          default: begin
            d.reg1_read = 1'b0;
            d.reg2_read = 1'b0;
            d.wreg      = 1'b0;
            d.invalid   = 1'b1;
          end
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        d.reg1_read = 1'b1;
        d.wreg      = 1'b1;
        d.wd        = inst[20:16];
        d.alusel    = ALUSEL_LOGIC;
        d.ext       = (inst[31:26] == OP_LUI) ? EXT_LUI : EXT_ZERO;
        d.aluop     = (inst[31:26] == OP_ANDI) ? ALUOP_AND :
                      (inst[31:26] == OP_XORI) ? ALUOP_XOR : ALUOP_OR;
      end
`ifdef ID_ARITH_EN
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        d.reg1_read = 1'b1;
        d.wreg      = 1'b1;
        d.wd        = inst[20:16];
        d.alusel    = ALUSEL_ARITH;
        d.ext       = EXT_SIGN;
        d.aluop     = (inst[31:26] == OP_ADDI)  ? ALUOP_ADDI  :
                      (inst[31:26] == OP_ADDIU) ? ALUOP_ADDIU :
                      (inst[31:26] == OP_SLTI)  ? ALUOP_SLT   : ALUOP_SLTU;
      end
`endif
      OP_PREF: d.wreg = 1'b0;
      default: d.invalid = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_stage_pipe_fwd_mux.sv
// id_fwd_mux: per-operand forwarding select; lowest matching slot wins, register 0 always reads 0.
module id_fwd_mux #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 2
) (
  input  logic [REG_AW-1:0]         i_addr,
  input  logic [DATA_W-1:0]         i_rf_data,
  input  logic [NUM_FWD-1:0]        i_fwd_wreg,
  input  logic [NUM_FWD*REG_AW-1:0] i_fwd_wd,
  input  logic [NUM_FWD*DATA_W-1:0] i_fwd_wdata,
  output logic [DATA_W-1:0]         o_data
);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_data = i_rf_data;
    // Walk from oldest to youngest so the lowest-index match is the last write.
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (i_fwd_wreg[i] && (i_fwd_wd[i*REG_AW +: REG_AW] == i_addr))
        o_data = i_fwd_wdata[i*DATA_W +: DATA_W];
    end
    if (i_addr == '0) o_data = '0;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode with forwarding, load-use stall and a handshaked ID/EX register.
// Build macro ID_ARITH_EN adds ADD/ADDU/SUB/SUBU/SLT/SLTU and ADDI/ADDIU/SLTI/SLTIU.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_FWD  = 2,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid_i,
  output logic                      id_ready_o,
  input  logic [DATA_W-1:0]         pc_i,
  input  logic [31:0]               inst_i,
  input  logic                      flush_i,
  input  logic [NUM_FWD-1:0]        fwd_wreg_i,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic                      ex_is_load_i,
  output logic                      reg1_read_o,
  output logic                      reg2_read_o,
  output logic [REG_AW-1:0]         reg1_addr_o,
  output logic [REG_AW-1:0]         reg2_addr_o,
  input  logic [DATA_W-1:0]         reg1_data_i,
  input  logic [DATA_W-1:0]         reg2_data_i,
  output logic                      ex_valid_o,
  input  logic                      ex_ready_i,
  output logic [ALUOP_W-1:0]        aluop_o,
  output logic [ALUSEL_W-1:0]       alusel_o,
  output logic [DATA_W-1:0]         reg1_data_o,
  output logic [DATA_W-1:0]         reg2_data_o,
  output logic [REG_AW-1:0]         wreg_addr_o,
  output logic                      wreg_enable_o,
  output logic [DATA_W-1:0]         pc_o,
  output logic                      stall_req_o,
  output logic                      inst_invalid_o
);

  localparam logic [ALUOP_W-1:0]  NOP_ALUOP  = ALUOP_W'(ALUOP_NOP);
  localparam logic [ALUSEL_W-1:0] NOP_ALUSEL = ALUSEL_W'(ALUSEL_NOP);

  dec_t                w_dec;
  logic [DATA_W-1:0]   w_imm, w_fwd1, w_fwd2, w_op1, w_op2;
  logic [REG_AW-1:0]   w_ld_wd;
  logic                w_adv, w_issue;

  logic                r_ex_valid, r_wreg_en, r_inst_invalid;
  logic [ALUOP_W-1:0]  r_aluop;
  logic [ALUSEL_W-1:0] r_alusel;
  logic [DATA_W-1:0]   r_reg1_data, r_reg2_data, r_pc;
  logic [REG_AW-1:0]   r_wreg_addr;

  assign w_dec       = decode(inst_i);
  assign w_imm       = DATA_W'(extend_imm(inst_i[15:0], inst_i[10:6], w_dec.ext));
  assign reg1_read_o = w_dec.reg1_read;
  assign reg2_read_o = w_dec.reg2_read;
  assign reg1_addr_o = REG_AW'(inst_i[25:21]);
  assign reg2_addr_o = REG_AW'(inst_i[20:16]);

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd1 (
    .i_addr      (reg1_addr_o),
    .i_rf_data   (reg1_data_i),
    .i_fwd_wreg  (fwd_wreg_i),
    .i_fwd_wd    (fwd_wd_i),
    .i_fwd_wdata (fwd_wdata_i),
    .o_data      (w_fwd1)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_fwd2 (
    .i_addr      (reg2_addr_o),
    .i_rf_data   (reg2_data_i),
    .i_fwd_wreg  (fwd_wreg_i),
    .i_fwd_wd    (fwd_wd_i),
    .i_fwd_wdata (fwd_wdata_i),
    .o_data      (w_fwd2)
  );

  assign w_op1 = reg1_read_o ? w_fwd1 : w_imm;
  assign w_op2 = reg2_read_o ? w_fwd2 : w_imm;

  // Slot 0 holds a load whose data arrives too late to forward this cycle.
  assign w_ld_wd     = fwd_wd_i[REG_AW-1:0];
  assign stall_req_o = id_valid_i & ex_is_load_i & fwd_wreg_i[0] & (w_ld_wd != '0)
                     & ((reg1_read_o & (w_ld_wd == reg1_addr_o))
                      | (reg2_read_o & (w_ld_wd == reg2_addr_o)));

  assign w_adv      = !r_ex_valid | ex_ready_i;
  assign id_ready_o = w_adv & !stall_req_o & !flush_i;
  assign w_issue    = id_valid_i & !stall_req_o & !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_ex_valid     <= 1'b0;
      r_wreg_en      <= 1'b0;
      r_aluop        <= NOP_ALUOP;
      r_alusel       <= NOP_ALUSEL;
      r_reg1_data    <= '0;
      r_reg2_data    <= '0;
      r_wreg_addr    <= '0;
      r_pc           <= '0;
      r_inst_invalid <= 1'b0;
    end else begin
      if (flush_i) begin
        r_ex_valid <= 1'b0;
        r_wreg_en  <= 1'b0;
        r_aluop    <= NOP_ALUOP;
        r_alusel   <= NOP_ALUSEL;
      end else if (w_adv) begin
        r_ex_valid  <= w_issue;
        r_wreg_en   <= w_issue & w_dec.wreg;
        r_aluop     <= w_issue ? ALUOP_W'(w_dec.aluop) : NOP_ALUOP;
        r_alusel    <= w_issue ? ALUSEL_W'(w_dec.alusel) : NOP_ALUSEL;
        r_reg1_data <= w_op1;
        r_reg2_data <= w_op2;
        r_wreg_addr <= REG_AW'(w_dec.wd);
        r_pc        <= pc_i;
      end
      if (id_valid_i && id_ready_o && w_dec.invalid) r_inst_invalid <= 1'b1;
    end
  end

  assign ex_valid_o     = r_ex_valid;
  assign wreg_enable_o  = r_wreg_en;
  assign aluop_o        = r_aluop;
  assign alusel_o       = r_alusel;
  assign reg1_data_o    = r_reg1_data;
  assign reg2_data_o    = r_reg2_data;
  assign wreg_addr_o    = r_wreg_addr;
  assign pc_o           = r_pc;
  assign inst_invalid_o = r_inst_invalid;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: expected ID/EX contents are queued on acceptance
// and compared when EX consumes them; directed checks cover stall, backpressure, flush, reset.
`timescale 1ns/1ps
module tb_id_stage_pipe;
  import id_stage_pipe_pkg::*;

  localparam int DATA_W = 32, REG_AW = 5, NUM_FWD = 2, ALUOP_W = 8, ALUSEL_W = 3;

  logic                      clk = 1'b0, rst = 1'b0;
  logic                      id_valid_i, id_ready_o, flush_i, ex_is_load_i;
  logic [DATA_W-1:0]         pc_i, reg1_data_i, reg2_data_i;
  logic [31:0]               inst_i;
  logic [NUM_FWD-1:0]        fwd_wreg_i;
  logic [NUM_FWD*REG_AW-1:0] fwd_wd_i;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i;
  logic                      reg1_read_o, reg2_read_o, ex_valid_o, ex_ready_i;
  logic [REG_AW-1:0]         reg1_addr_o, reg2_addr_o, wreg_addr_o;
  logic [ALUOP_W-1:0]        aluop_o;
  logic [ALUSEL_W-1:0]       alusel_o;
  logic [DATA_W-1:0]         reg1_data_o, reg2_data_o, pc_o;
  logic                      wreg_enable_o, stall_req_o, inst_invalid_o;

  always #5 clk = ~clk;

  id_stage_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD),
                  .ALUOP_W(ALUOP_W), .ALUSEL_W(ALUSEL_W)) dut (
    .clk(clk), .rst(rst), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .pc_i(pc_i),
    .inst_i(inst_i), .flush_i(flush_i), .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i),
    .fwd_wdata_i(fwd_wdata_i), .ex_is_load_i(ex_is_load_i), .reg1_read_o(reg1_read_o),
    .reg2_read_o(reg2_read_o), .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i), .ex_valid_o(ex_valid_o),
    .ex_ready_i(ex_ready_i), .aluop_o(aluop_o), .alusel_o(alusel_o),
    .reg1_data_o(reg1_data_o), .reg2_data_o(reg2_data_o), .wreg_addr_o(wreg_addr_o),
    .wreg_enable_o(wreg_enable_o), .pc_o(pc_o), .stall_req_o(stall_req_o),
    .inst_invalid_o(inst_invalid_o)
  );

  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] r1, r2, pc;
    logic [4:0]  waddr;
    logic        wen, chk_data;
  } exp_t;

  exp_t sb[$];
  exp_t nx;
  int   n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic exp_t mk(input logic [7:0] aluop, input logic [2:0] alusel,
                              input logic [31:0] r1, r2, input logic [4:0] waddr,
                              input logic wen, input logic [31:0] pc);
    exp_t e;
    e.aluop = aluop; e.alusel = alusel; e.r1 = r1; e.r2 = r2; e.pc = pc;
    e.waddr = waddr; e.wen = wen; e.chk_data = 1'b1;
    return e;
  endfunction

  task automatic cmp(input exp_t e);
    check("aluop", aluop_o, e.aluop);
    check("alusel", alusel_o, e.alusel);
    check("wreg_en", wreg_enable_o, e.wen);
    check("pc", pc_o, e.pc);
    if (e.chk_data) begin
      check("reg1_data", reg1_data_o, e.r1);
      check("reg2_data", reg2_data_o, e.r2);
      check("wreg_addr", wreg_addr_o, e.waddr);
    end
  endtask

  // One clock: check ready, retire a consumed entry, queue an accepted one, advance.
  task automatic cycle(input logic exp_ready);
    exp_t e;
    #1;
    check("id_ready", id_ready_o, exp_ready);
    if (ex_valid_o && ex_ready_i) begin
      if (sb.size() == 0) check("sb_underflow", ex_valid_o, 1'b0);
      else begin
        e = sb.pop_front();
        cmp(e);
      end
    end
    if (id_valid_i && exp_ready) sb.push_back(nx);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2);
    id_valid_i = 1'b1; inst_i = inst; pc_i = pc; reg1_data_i = d1; reg2_data_i = d2;
  endtask

  initial begin
    id_valid_i = 0; pc_i = 0; inst_i = 0; flush_i = 0; ex_is_load_i = 0; ex_ready_i = 1;
    fwd_wreg_i = 0; fwd_wd_i = 0; fwd_wdata_i = 0; reg1_data_i = 0; reg2_data_i = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", ex_valid_o, 1'b0);
    check("rst_wen", wreg_enable_o, 1'b0);
    check("rst_aluop", aluop_o, ALUOP_NOP);
    check("rst_alusel", alusel_o, ALUSEL_NOP);
    check("rst_invalid", inst_invalid_o, 1'b0);
    check("rst_pc", pc_o, 0);
    rst = 1'b1;

    // ORI $2,$1,0xFF00 with EX and MEM both forwarding $1: EX wins.
    set_op(i_ins(6'h0D, 1, 2, 16'hFF00), 32'h100, 32'h9999, 32'h0);
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'h5555, 32'h1234};
    nx = mk(ALUOP_OR, ALUSEL_LOGIC, 32'h1234, 32'h0000FF00, 2, 1, 32'h100);
    #1;
    check("ori_rd1", reg1_read_o, 1'b1);
    check("ori_rd2", reg2_read_o, 1'b0);
    check("ori_addr1", reg1_addr_o, 1);
    cycle(1);
    // Only MEM matches.
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd7};
    nx = mk(ALUOP_OR, ALUSEL_LOGIC, 32'h5555, 32'h0000FF00, 2, 1, 32'h104);
    pc_i = 32'h104;
    cycle(1);
    fwd_wreg_i = 0;
    set_op(i_ins(6'h0C, 1, 5, 16'h8001), 32'h108, 32'hF0F0, 32'h0);
    nx = mk(ALUOP_AND, ALUSEL_LOGIC, 32'hF0F0, 32'h00008001, 5, 1, 32'h108);
    cycle(1);
    set_op(i_ins(6'h0F, 0, 9, 16'h8001), 32'h10C, 32'hBEEF, 32'h0);
    nx = mk(ALUOP_OR, ALUSEL_LOGIC, 32'h0, 32'h80010000, 9, 1, 32'h10C);
    cycle(1);

    // Back-to-back XORs at full throughput.
    for (int i = 1; i <= 4; i++) begin
      set_op(r_ins(5'(i), 5'(i + 1), 5'(i + 8), 0, 6'h26), 32'h200 + 4 * i, 32'h11 * i, 32'h100 * i);
      nx = mk(ALUOP_XOR, ALUSEL_LOGIC, 32'h11 * i, 32'h100 * i, 5'(i + 8), 1, 32'h200 + 4 * i);
      cycle(1);
    end

    // Load-use on $3.
    ex_is_load_i = 1; fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd3}; fwd_wdata_i = {32'h0, 32'hBAD0};
    set_op(r_ins(3, 5, 4, 0, 6'h25), 32'h300, 32'h1111, 32'h5050);
    #1 check("stall_hit", stall_req_o, 1'b1);
    cycle(0);
    check("bubble_valid", ex_valid_o, 1'b0);
    check("bubble_wen", wreg_enable_o, 1'b0);
    check("bubble_aluop", aluop_o, ALUOP_NOP);
    cycle(0);
    ex_is_load_i = 0; fwd_wdata_i = {32'h0, 32'h3333};
    nx = mk(ALUOP_OR, ALUSEL_LOGIC, 32'h3333, 32'h5050, 4, 1, 32'h300);
    #1 check("stall_clear", stall_req_o, 1'b0);
    cycle(1);
    id_valid_i = 0; ex_is_load_i = 1;
    #1 check("stall_novalid", stall_req_o, 1'b0);
    // Load targeting $0 never stalls and $0 never forwards.
    id_valid_i = 1; fwd_wd_i = {5'd0, 5'd0};
    set_op(r_ins(0, 5, 4, 0, 6'h25), 32'h304, 32'h7777, 32'h5151);
    nx = mk(ALUOP_OR, ALUSEL_LOGIC, 32'h0, 32'h5151, 4, 1, 32'h304);
    #1 check("stall_r0", stall_req_o, 1'b0);
    cycle(1);
    ex_is_load_i = 0; fwd_wreg_i = 0;

    // Backpressure: EX stalls 3 cycles with NOR held, AND waits.
    set_op(r_ins(1, 2, 20, 0, 6'h27), 32'h400, 32'hA1, 32'hA2);
    nx = mk(ALUOP_NOR, ALUSEL_LOGIC, 32'hA1, 32'hA2, 20, 1, 32'h400);
    cycle(1);
    ex_ready_i = 0;
    set_op(r_ins(2, 3, 21, 0, 6'h24), 32'h404, 32'hB2, 32'hB3);
    nx = mk(ALUOP_AND, ALUSEL_LOGIC, 32'hB2, 32'hB3, 21, 1, 32'h404);
    for (int k = 0; k < 3; k++) begin
      cycle(0);
      check("hold_valid", ex_valid_o, 1'b1);
      check("hold_r1", reg1_data_o, 32'hA1);
      check("hold_pc", pc_o, 32'h400);
    end
    ex_ready_i = 1;
    cycle(1);

    // Flush while EX is stalled drops the held op.
    set_op(r_ins(4, 5, 22, 0, 6'h26), 32'h500, 32'hC4, 32'hC5);
    nx = mk(ALUOP_XOR, ALUSEL_LOGIC, 32'hC4, 32'hC5, 22, 1, 32'h500);
    cycle(1);
    flush_i = 1; ex_ready_i = 0;
    set_op(i_ins(6'h0D, 1, 3, 16'h0001), 32'h504, 32'hD1, 32'h0);
    cycle(0);
    check("flush_valid", ex_valid_o, 1'b0);
    check("flush_wen", wreg_enable_o, 1'b0);
    sb.delete();
    flush_i = 0; ex_ready_i = 1;

    // SLL $6,$7,4 with MEM writing $0; then rt=$0.
    fwd_wreg_i = 2'b11; fwd_wd_i = {5'd0, 5'd0}; fwd_wdata_i = {32'hDEAD, 32'hDEAD};
    set_op(r_ins(0, 7, 6, 4, 6'h00), 32'h600, 32'h0, 32'h7777);
    nx = mk(ALUOP_SLL, ALUSEL_SHIFT, 32'h4, 32'h7777, 6, 1, 32'h600);
    #1;
    check("sll_rd1", reg1_read_o, 1'b0);
    check("sll_addr2", reg2_addr_o, 7);
    cycle(1);
    set_op(r_ins(0, 0, 6, 4, 6'h00), 32'h604, 32'h0, 32'h0BAD);
    nx = mk(ALUOP_SLL, ALUSEL_SHIFT, 32'h4, 32'h0, 6, 1, 32'h604);
    cycle(1);
    fwd_wreg_i = 0;

    // Asynchronous reset with a valid op in ID/EX.
    set_op(r_ins(1, 2, 3, 0, 6'h26), 32'h700, 32'hE1, 32'hE2);
    nx = mk(ALUOP_XOR, ALUSEL_LOGIC, 32'hE1, 32'hE2, 3, 1, 32'h700);
    cycle(1);
    check("pre_rst_valid", ex_valid_o, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", ex_valid_o, 1'b0);
    check("arst_wen", wreg_enable_o, 1'b0);
    check("arst_aluop", aluop_o, ALUOP_NOP);
    check("arst_r1", reg1_data_o, 0);
    check("arst_pc", pc_o, 0);
    sb.delete();
    id_valid_i = 0;
    @(negedge clk);
    rst = 1'b1;
    set_op(r_ins(11, 12, 10, 0, 6'h24), 32'h800, 32'hF1, 32'hF2);
    nx = mk(ALUOP_AND, ALUSEL_LOGIC, 32'hF1, 32'hF2, 10, 1, 32'h800);
    cycle(1);

    // Undecodable opcode, then ADDI $1,$0,-1.
    check("invalid_clear", inst_invalid_o, 1'b0);
    set_op({6'h3F, 26'h0}, 32'h900, 32'h0, 32'h0);
    nx = mk(ALUOP_NOP, ALUSEL_NOP, 0, 0, 0, 0, 32'h900);
    nx.chk_data = 0;
    cycle(1);
    check("invalid_set", inst_invalid_o, 1'b1);
    set_op(i_ins(6'h08, 0, 1, 16'hFFFF), 32'h904, 32'hBEEF, 32'h0);
`ifdef ID_ARITH_EN
    nx = mk(ALUOP_ADDI, ALUSEL_ARITH, 32'h0, 32'hFFFFFFFF, 1, 1, 32'h904);
`else
    nx = mk(ALUOP_NOP, ALUSEL_NOP, 0, 0, 0, 0, 32'h904);
    nx.chk_data = 0;
`endif
    cycle(1);
    id_valid_i = 0;
    repeat (3) cycle(1);
    check("invalid_sticky", inst_invalid_o, 1'b1);
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
